rect_pos_ctl: RTL and testbench
===============================

Name: rect_pos_ctl

Overview:
- Owns the x_pointer/y_pointer coordinates that drive the rectangle overlay stage in the VGA pipeline.
- Arbitrates, round-robin, between two position requesters:
  - absolute: mouse position;
  - relative: keyboard step commands.
- Commits at most one update per frame, only at vertical-blank start, so the overlay never tears mid-frame.
- Clamps every result so the whole rectangle stays inside the active area.

Parameters:
- H_ACTIVE, 800, active pixels per line
- V_ACTIVE, 600, active lines per frame
- RECT_LONG, 10, rectangle width extent (drawn x..x+RECT_LONG)
- RECT_HIGH, 16, rectangle height extent (drawn y..y+RECT_HIGH)
- STEP, 4, pixels moved per relative command per axis
- X_INIT, 395, reset x_pointer
- Y_INIT, 292, reset y_pointer

Ports:
- clk  input  1  pixel clock
- rst  input  1  asynchronous, active-low reset
- vblnk_in  input  1  vertical blank from timing chain
- abs_req  input  1  absolute-move request, held until abs_ack
- abs_x  input  11  requested x; stable while abs_req=1
- abs_y  input  11  requested y; stable while abs_req=1
- abs_ack  output  1  one-cycle grant/commit pulse to absolute requester
- rel_req  input  1  relative-move request, held until rel_ack
- rel_dir  input  4  {up,down,left,right}; stable while rel_req=1
- rel_ack  output  1  one-cycle grant/commit pulse to relative requester
- x_pointer  output  11  committed rectangle x
- y_pointer  output  11  committed rectangle y
- frame_tick  output  1  one-cycle pulse on every vblank rising edge

Behaviour:
- Reset (rst=0, async) values:
  - x_pointer=X_INIT, y_pointer=Y_INIT;
  - abs_ack=0, rel_ack=0, frame_tick=0;
  - FSM=IDLE, vblnk_d=0;
  - last_grant=REL, so ABS wins the first contested arbitration.
- Reset asserted mid-operation: pending work is abandoned and no ack is issued.
- Derived constants:
  - X_MAX = H_ACTIVE-1-RECT_LONG = 789;
  - Y_MAX = V_ACTIVE-1-RECT_HIGH = 583.
- Vblank edge detection:
  - vblnk_d is a registered copy of vblnk_in; rise = vblnk_in & ~vblnk_d.
  - frame_tick is a registered output: high for the single cycle after rise is sampled.
- FSM states: IDLE, ARB, CALC, COMMIT.
  - IDLE: on rise -> ARB. Otherwise stay.
  - ARB: samples abs_req/rel_req and their operands into internal registers.
    - Neither request -> IDLE.
    - One request -> grant it.
    - Both requests -> grant the one not equal to last_grant.
    - Update last_grant only when a grant is made. Next state CALC.
  - CALC: computes the target through a 12-bit signed intermediate, then clamps; result is registered. -> COMMIT.
    - ABS target: x = min(abs_x, X_MAX), y = min(abs_y, Y_MAX).
    - REL target:
      - dx = +STEP if right only, -STEP if left only, 0 if both or neither;
      - dy = -STEP if up only, +STEP if down only, 0 if both or neither;
      - result < 0 -> clamp to 0; result > max -> clamp to max.
  - COMMIT: x_pointer/y_pointer load the clamped target; the granted ack goes high for exactly this one cycle. -> IDLE.
- Latency: with rise sampled at edge N, pointers and ack become visible after edge N+3 and hold through COMMIT; ack deasserts after edge N+4.
- Pointers change only in COMMIT and are otherwise stable all frame.
- Handshake rules:
  - A requester keeps req high until it sees ack, and drops req the cycle after ack.
  - A req dropped before ARB sampling is simply missed; no error.
  - Request changes after ARB do not affect the in-flight update.
  - The ungranted requester waits for a later frame.
  - At most one ack per frame, and never both acks at once.
- A vblank rise detected while not in IDLE is ignored. This cannot happen at real frame rates, but it must not corrupt state.

Decomposition:
- Shared package (vga_pkg): H_ACTIVE, V_ACTIVE, RECT_LONG, RECT_HIGH, grant enum {GNT_ABS, GNT_REL}, FSM state enum.
- RECT_LONG/RECT_HIGH values are shared with the overlay stage so the two blocks agree.
- One natural sub-module: pos_clamp. It is combinational: signed 12-bit value plus max in, saturated 11-bit value out. It is used twice, once for x and once for y.

Test Plan:
- Reset release, no requests, 3 frames -> x_pointer=395, y_pointer=292 constant; frame_tick pulses once per vblank rise; no acks.
- abs_req=1, abs_x=100, abs_y=50 before vblank -> after vblank rise: pointers=100/50 at N+3, abs_ack exactly one cycle.
- abs_x=900, abs_y=700 -> pointers=789/583. Then rel_dir=right repeatedly from x=789 -> x stays 789, rel_ack each frame.
- x=2, rel_dir=left -> x=0 (no wrap to 2046). rel_dir=up+down+right from y=292, x=0 -> y=292, x=4.
- Both reqs held across 4 frames from reset -> grants alternate ABS, REL, ABS, REL; exactly one ack per frame, never both.
- Assert rst low during CALC -> pointers return to 395/292 immediately, no ack. Request after release is served on the next vblank.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared VGA geometry, grant and FSM types used by the rectangle position
// controller and the overlay stage.
package vga_pkg;

    localparam int H_ACTIVE  = 800;
    localparam int V_ACTIVE  = 600;
    localparam int RECT_LONG = 10;
    localparam int RECT_HIGH = 16;

    typedef enum logic {
        GNT_ABS,
        GNT_REL
    } grant_e;

    typedef enum logic [1:0] {
        IDLE,
        ARB,
        CALC,
        COMMIT
    } state_e;

endpackage

// File: rtl/pos_clamp.sv
// Saturates a signed 12-bit coordinate into the range 0..max_val.
module pos_clamp (
    input  logic signed [11:0] value,
    input  logic        [10:0] max_val,
    output logic        [10:0] result
);

    always_comb begin
        result = value[10:0];
        if (value < 12'sd0) begin
            result = '0;
        end else if (value[10:0] > max_val) begin
            result = max_val;
        end
    end

endmodule

// File: rtl/rect_pos_ctl.sv
// Rectangle position owner: arbitrates absolute/relative move requests and
// commits at most one clamped update per frame at vertical-blank start.
//
// Handshake: each requester raises req with stable operands and holds it
// until it sees its one-cycle ack; the ack coincides with the new pointers.
module rect_pos_ctl
    import vga_pkg::*;
#(
    parameter int STEP   = 4,
    parameter int X_INIT = 395,
    parameter int Y_INIT = 292
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        vblnk_in,
    input  logic        abs_req,
    input  logic [10:0] abs_x,
    input  logic [10:0] abs_y,
    output logic        abs_ack,
    input  logic        rel_req,
    input  logic [3:0]  rel_dir,
    output logic        rel_ack,
    output logic [10:0] x_pointer,
    output logic [10:0] y_pointer,
    output logic        frame_tick,
    output state_e      fsm_state
);

    localparam logic [10:0] X_MAX = 11'(H_ACTIVE - 1 - RECT_LONG);
    localparam logic [10:0] Y_MAX = 11'(V_ACTIVE - 1 - RECT_HIGH);

    state_e             state;
    grant_e             last_grant;
    grant_e             grant;
    logic               vblnk_d;
    logic               rise;
    logic [10:0]        req_x;
    logic [10:0]        req_y;
    logic [3:0]         req_dir;
    logic [10:0]        tgt_x;
    logic [10:0]        tgt_y;
    logic signed [11:0] dx;
    logic signed [11:0] dy;
    logic signed [11:0] raw_x;
    logic signed [11:0] raw_y;
    logic [10:0]        clamp_x;
    logic [10:0]        clamp_y;

    assign rise      = vblnk_in & ~vblnk_d;
    assign fsm_state = state;

    // rel_dir bits are {up, down, left, right}; opposing bits cancel.
    always_comb begin
        dx = '0;
        dy = '0;
        if (req_dir[0] && !req_dir[1]) dx = 12'(STEP);
        else if (req_dir[1] && !req_dir[0]) dx = -12'(STEP);
        if (req_dir[2] && !req_dir[3]) dy = 12'(STEP);
        else if (req_dir[3] && !req_dir[2]) dy = -12'(STEP);

        if (grant == GNT_ABS) begin
            raw_x = $signed({1'b0, req_x});
            raw_y = $signed({1'b0, req_y});
        end else begin
            raw_x = $signed({1'b0, x_pointer}) + dx;
            raw_y = $signed({1'b0, y_pointer}) + dy;
        end
    end

    pos_clamp u_clamp_x (.value(raw_x), .max_val(X_MAX), .result(clamp_x));
    pos_clamp u_clamp_y (.value(raw_y), .max_val(Y_MAX), .result(clamp_y));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            last_grant <= GNT_REL;
            grant      <= GNT_ABS;
            vblnk_d    <= 1'b0;
            frame_tick <= 1'b0;
            abs_ack    <= 1'b0;
            rel_ack    <= 1'b0;
            req_x      <= '0;
            req_y      <= '0;
            req_dir    <= '0;
            tgt_x      <= '0;
            tgt_y      <= '0;
            x_pointer  <= 11'(X_INIT);
            y_pointer  <= 11'(Y_INIT);
        end else begin
            vblnk_d    <= vblnk_in;
            frame_tick <= rise;
            abs_ack    <= 1'b0;
            rel_ack    <= 1'b0;
            case (state)
                IDLE: begin
                    // A rise seen in any other state is deliberately dropped.
                    if (rise) state <= ARB;
                end
                ARB: begin
                    req_x   <= abs_x;
                    req_y   <= abs_y;
                    req_dir <= rel_dir;
                    if (abs_req && (!rel_req || last_grant == GNT_REL)) begin
                        grant      <= GNT_ABS;
                        last_grant <= GNT_ABS;
                        state      <= CALC;
                    end else if (rel_req) begin
                        grant      <= GNT_REL;
                        last_grant <= GNT_REL;
                        state      <= CALC;
                    end else begin
                        state <= IDLE;
                    end
                end
                CALC: begin
                    tgt_x <= clamp_x;
                    tgt_y <= clamp_y;
                    state <= COMMIT;
                end
                COMMIT: begin
                    x_pointer <= tgt_x;
                    y_pointer <= tgt_y;
                    abs_ack   <= (grant == GNT_ABS);
                    rel_ack   <= (grant == GNT_REL);
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rect_pos_ctl.sv
// Self-checking bench for rect_pos_ctl: directed frames plus randomized
// request traffic compared against a plain arithmetic position model.
module tb_rect_pos_ctl;
    import vga_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        vblnk_in = 1'b0;
    logic        abs_req = 1'b0;
    logic [10:0] abs_x = '0;
    logic [10:0] abs_y = '0;
    logic        abs_ack;
    logic        rel_req = 1'b0;
    logic [3:0]  rel_dir = '0;
    logic        rel_ack;
    logic [10:0] x_pointer;
    logic [10:0] y_pointer;
    logic        frame_tick;
    state_e      dbg_state;

    int n_checks = 0;
    int n_errors = 0;

    // model state
    int xm = 395;
    int ym = 292;
    bit last_rel = 1'b1;

    // per-frame observations
    int fr_abs, fr_rel, fr_tick, fr_both, fr_ack_ofs, fr_chg;
    int fr_x, fr_y, fr_x_pre, fr_y_pre;

    rect_pos_ctl dut (
        .clk(clk), .rst(rst), .vblnk_in(vblnk_in),
        .abs_req(abs_req), .abs_x(abs_x), .abs_y(abs_y), .abs_ack(abs_ack),
        .rel_req(rel_req), .rel_dir(rel_dir), .rel_ack(rel_ack),
        .x_pointer(x_pointer), .y_pointer(y_pointer),
        .frame_tick(frame_tick), .fsm_state(dbg_state)
    );

    always #5 clk = ~clk;

    function automatic int clampi(input int v, input int mx);
        if (v < 0) return 0;
        if (v > mx) return mx;
        return v;
    endfunction

    task automatic do_reset();
        rst = 1'b0;
        vblnk_in = 1'b0;
        abs_req = 1'b0;
        rel_req = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        xm = 395;
        ym = 292;
        last_rel = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    // One vblank: raise vblnk_in, watch 12 cycles, requester drops req on ack.
    task automatic run_frame(input bit glitch);
        logic [10:0] px, py;
        fr_abs = 0; fr_rel = 0; fr_tick = 0; fr_both = 0; fr_ack_ofs = -1; fr_chg = 0;
        @(negedge clk);
        vblnk_in = 1'b1;
        px = x_pointer;
        py = y_pointer;
        fr_x_pre = int'(x_pointer);
        fr_y_pre = int'(y_pointer);
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (frame_tick) fr_tick++;
            if (abs_ack && rel_ack) fr_both++;
            if (abs_ack) begin fr_abs++; fr_ack_ofs = c; abs_req = 1'b0; end
            if (rel_ack) begin fr_rel++; fr_ack_ofs = c; rel_req = 1'b0; end
            if ((x_pointer !== px || y_pointer !== py) && c != 3) fr_chg++;
            px = x_pointer;
            py = y_pointer;
            if (glitch && c == 0) vblnk_in = 1'b0;
            if (glitch && c == 1) vblnk_in = 1'b1;
            if (c == 5) vblnk_in = 1'b0;
        end
        fr_x = int'(x_pointer);
        fr_y = int'(y_pointer);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++; if (x_pointer !== 11'd395) begin n_errors++; $display("FAIL rst_x got %0d exp 395", x_pointer); end
        n_checks++; if (y_pointer !== 11'd292) begin n_errors++; $display("FAIL rst_y got %0d exp 292", y_pointer); end
        n_checks++; if (abs_ack !== 1'b0 || rel_ack !== 1'b0) begin n_errors++; $display("FAIL rst_ack got %b%b exp 00", abs_ack, rel_ack); end
        n_checks++; if (frame_tick !== 1'b0) begin n_errors++; $display("FAIL rst_tick got %b exp 0", frame_tick); end
        n_checks++; if (dbg_state !== IDLE) begin n_errors++; $display("FAIL rst_state got %0d exp %0d", dbg_state, IDLE); end
        do_reset();
        for (int f = 0; f < 3; f++) begin
            run_frame(1'b0);
            n_checks++; if (fr_tick != 1) begin n_errors++; $display("FAIL idle_tick got %0d exp 1", fr_tick); end
            n_checks++; if (fr_abs + fr_rel != 0) begin n_errors++; $display("FAIL idle_ack got %0d exp 0", fr_abs + fr_rel); end
            n_checks++; if (fr_x != 395 || fr_y != 292 || fr_chg != 0) begin n_errors++; $display("FAIL idle_ptr got %0d/%0d chg %0d exp 395/292 chg 0", fr_x, fr_y, fr_chg); end
        end
    endtask

    task automatic test_abs();
        abs_req = 1'b1; abs_x = 11'd100; abs_y = 11'd50;
        run_frame(1'b0);
        n_checks++; if (fr_abs != 1 || fr_rel != 0) begin n_errors++; $display("FAIL abs_ack got %0d/%0d exp 1/0", fr_abs, fr_rel); end
        n_checks++; if (fr_ack_ofs != 3) begin n_errors++; $display("FAIL abs_latency got %0d exp 3", fr_ack_ofs); end
        n_checks++; if (fr_x != 100 || fr_y != 50) begin n_errors++; $display("FAIL abs_ptr got %0d/%0d exp 100/50", fr_x, fr_y); end
        n_checks++; if (fr_x_pre != 395 || fr_chg != 0) begin n_errors++; $display("FAIL abs_stable got pre %0d chg %0d exp 395 0", fr_x_pre, fr_chg); end
        xm = 100; ym = 50; last_rel = 1'b0;
    endtask

    task automatic test_abs_clamp();
        abs_req = 1'b1; abs_x = 11'd900; abs_y = 11'd700;
        run_frame(1'b0);
        n_checks++; if (fr_x != 789 || fr_y != 583) begin n_errors++; $display("FAIL abs_clamp got %0d/%0d exp 789/583", fr_x, fr_y); end
        for (int f = 0; f < 3; f++) begin
            rel_req = 1'b1; rel_dir = 4'b0001;
            run_frame(1'b0);
            n_checks++; if (fr_rel != 1 || fr_abs != 0) begin n_errors++; $display("FAIL right_ack got %0d/%0d exp 0/1", fr_abs, fr_rel); end
            n_checks++; if (fr_x != 789 || fr_y != 583) begin n_errors++; $display("FAIL right_clamp got %0d/%0d exp 789/583", fr_x, fr_y); end
        end
        xm = 789; ym = 583; last_rel = 1'b1;
    endtask

    task automatic test_rel_edges();
        abs_req = 1'b1; abs_x = 11'd2; abs_y = 11'd292;
        run_frame(1'b0);
        rel_req = 1'b1; rel_dir = 4'b0010;
        run_frame(1'b0);
        n_checks++; if (fr_x != 0 || fr_y != 292) begin n_errors++; $display("FAIL left_clamp got %0d/%0d exp 0/292", fr_x, fr_y); end
        rel_req = 1'b1; rel_dir = 4'b1101;
        run_frame(1'b0);
        n_checks++; if (fr_x != 4 || fr_y != 292 || fr_rel != 1) begin n_errors++; $display("FAIL updown_right got %0d/%0d ack %0d exp 4/292 ack 1", fr_x, fr_y, fr_rel); end
        xm = 4; ym = 292; last_rel = 1'b1;
    endtask

    task automatic test_arbitration();
        int exp_abs;
        do_reset();
        for (int f = 0; f < 4; f++) begin
            abs_req = 1'b1; abs_x = 11'd10; abs_y = 11'd20;
            rel_req = 1'b1; rel_dir = 4'b0001;
            exp_abs = (f % 2 == 0) ? 1 : 0;
            run_frame(1'b0);
            n_checks++; if (fr_abs != exp_abs || fr_rel != 1 - exp_abs) begin n_errors++; $display("FAIL arb_grant frame %0d got %0d/%0d exp %0d/%0d", f, fr_abs, fr_rel, exp_abs, 1 - exp_abs); end
            n_checks++; if (fr_both != 0) begin n_errors++; $display("FAIL arb_both got %0d exp 0", fr_both); end
            n_checks++; if (fr_x != (exp_abs ? 10 : 14) || fr_y != 20) begin n_errors++; $display("FAIL arb_ptr got %0d/%0d exp %0d/20", fr_x, fr_y, exp_abs ? 10 : 14); end
        end
        abs_req = 1'b0; rel_req = 1'b0;
        xm = 14; ym = 20; last_rel = 1'b1;
    endtask

    task automatic test_rise_while_busy();
        abs_req = 1'b1; abs_x = 11'd300; abs_y = 11'd300;
        run_frame(1'b1);
        n_checks++; if (fr_tick != 2) begin n_errors++; $display("FAIL busy_tick got %0d exp 2", fr_tick); end
        n_checks++; if (fr_abs != 1 || fr_rel != 0 || fr_x != 300 || fr_y != 300) begin n_errors++; $display("FAIL busy_commit got ack %0d/%0d ptr %0d/%0d exp 1/0 300/300", fr_abs, fr_rel, fr_x, fr_y); end
        xm = 300; ym = 300; last_rel = 1'b0;
    endtask

    task automatic test_random();
        int ax, ay, ex_abs, ex_rel, sx, sy;
        logic [3:0] d;
        for (int f = 0; f < 40; f++) begin
            if (!abs_req && $urandom_range(0, 1) == 1) begin
                abs_req = 1'b1;
                abs_x = 11'($urandom_range(0, 2047));
                abs_y = 11'($urandom_range(0, 2047));
            end
            if (!rel_req && $urandom_range(0, 2) != 0) begin
                rel_req = 1'b1;
                rel_dir = 4'($urandom_range(0, 15));
            end
            ax = int'(abs_x); ay = int'(abs_y); d = rel_dir;
            ex_abs = (abs_req && (!rel_req || last_rel)) ? 1 : 0;
            ex_rel = (!ex_abs && rel_req) ? 1 : 0;
            if (ex_abs == 1) begin
                xm = clampi(ax, 789); ym = clampi(ay, 583); last_rel = 1'b0;
            end else if (ex_rel == 1) begin
                sx = (d[0] ? 4 : 0) - (d[1] ? 4 : 0);
                sy = (d[2] ? 4 : 0) - (d[3] ? 4 : 0);
                xm = clampi(xm + sx, 789); ym = clampi(ym + sy, 583); last_rel = 1'b1;
            end
            run_frame(1'b0);
            n_checks++; if (fr_abs != ex_abs || fr_rel != ex_rel || fr_both != 0) begin n_errors++; $display("FAIL rnd_grant frame %0d got %0d/%0d exp %0d/%0d", f, fr_abs, fr_rel, ex_abs, ex_rel); end
            n_checks++; if (fr_x != xm || fr_y != ym || fr_chg != 0) begin n_errors++; $display("FAIL rnd_ptr frame %0d got %0d/%0d chg %0d exp %0d/%0d", f, fr_x, fr_y, fr_chg, xm, ym); end
        end
        abs_req = 1'b0; rel_req = 1'b0;
    endtask

    task automatic test_reset_mid();
        int acks = 0;
        abs_req = 1'b1; abs_x = 11'd600; abs_y = 11'd400;
        @(negedge clk); vblnk_in = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_checks++; if (x_pointer !== 11'd395 || y_pointer !== 11'd292) begin n_errors++; $display("FAIL mid_rst_ptr got %0d/%0d exp 395/292", x_pointer, y_pointer); end
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (abs_ack || rel_ack) acks++;
        end
        vblnk_in = 1'b0;
        rst = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (abs_ack || rel_ack) acks++;
        end
        n_checks++; if (acks != 0) begin n_errors++; $display("FAIL mid_rst_ack got %0d exp 0", acks); end
        xm = 395; ym = 292; last_rel = 1'b1;
        run_frame(1'b0);
        n_checks++; if (fr_abs != 1 || fr_x != 600 || fr_y != 400) begin n_errors++; $display("FAIL post_rst_serve got ack %0d ptr %0d/%0d exp 1 600/400", fr_abs, fr_x, fr_y); end
    endtask

    initial begin
        test_reset();
        test_abs();
        test_abs_clamp();
        test_rel_edges();
        test_arbitration();
        test_rise_while_busy();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
